// File: rtl/sprite_motion_if.sv
// Keyboard-in / sprite-out bundle between the input logic and the sprite motion controller.
// master drives the keycode and observes the sprite; slave is the controller itself.
interface sprite_motion_if #(
    parameter int unsigned ANIM_FRAMES = 4
);
    localparam int unsigned AW = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;

    logic [7:0]    Keycode;
    logic [9:0]    spritex;
    logic [9:0]    spritey;
    logic          facing_left;
    logic [AW-1:0] anim_sel;
    logic          airborne;

    modport master (
        output Keycode,
        input  spritex,
        input  spritey,
        input  facing_left,
        input  anim_sel,
        input  airborne
    );

    modport slave (
        input  Keycode,
        output spritex,
        output spritey,
        output facing_left,
        output anim_sel,
        output airborne
    );
endinterface

// File: rtl/sprite_motion_ctrl.sv
// Per-frame player sprite controller: clamped horizontal walk, jump/gravity FSM,
// facing flag and walk-cycle frame selector, all updated once per vsync edge.
module sprite_motion_ctrl #(
    parameter int unsigned X_START     = 290,
    parameter int unsigned Y_START     = 350,
    parameter int unsigned X_MIN       = 0,
    parameter int unsigned X_MAX       = 639,
    parameter int unsigned SPRITE_W    = 32,
    parameter int unsigned Y_MIN       = 0,
    parameter int unsigned X_STEP      = 2,
    parameter int unsigned JUMP_V      = 8,
    parameter int unsigned GRAVITY     = 1,
    parameter int unsigned MAX_FALL    = 8,
    parameter int unsigned ANIM_FRAMES = 4,
    parameter int unsigned ANIM_DIV    = 6,
    parameter int unsigned KEY_LEFT    = 80,
    parameter int unsigned KEY_RIGHT   = 79,
    parameter int unsigned KEY_JUMP    = 82
) (
    input  logic             frame_clk,
    input  logic             Reset_n,
    sprite_motion_if.slave   bus
);

    localparam int unsigned AW = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
    localparam int unsigned DW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

    localparam logic [10:0] X_LIM_11   = 11'(X_MAX - SPRITE_W + 1);
    localparam logic [10:0] X_MIN_11   = 11'(X_MIN);
    localparam logic [10:0] STEP_11    = 11'(X_STEP);
    localparam logic [9:0]  STEP_10    = 10'(X_STEP);
    localparam logic [10:0] Y_START_11 = 11'(Y_START);
    localparam logic [10:0] Y_MIN_11   = 11'(Y_MIN);
    localparam logic [5:0]  JUMP_V_6   = 6'(JUMP_V);
    localparam logic [5:0]  GRAV_6     = 6'(GRAVITY);
    localparam logic [6:0]  GRAV_7     = 7'(GRAVITY);
    localparam logic [6:0]  MAX_FALL_7 = 7'(MAX_FALL);
    localparam logic [DW-1:0] DIV_LAST = DW'(ANIM_DIV - 1);

    typedef enum logic [1:0] {
        ST_GROUND = 2'd0,
        ST_RISE   = 2'd1,
        ST_FALL   = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [9:0]    x_q, x_d;
    logic [9:0]    y_q, y_d;
    logic [5:0]    v_q, v_d;
    logic          facing_q, facing_d;
    logic [AW-1:0] anim_q, anim_d;
    logic [DW-1:0] div_q, div_d;
    logic          airborne_q, airborne_d;

    logic key_left, key_right, key_jump, key_walk;
    assign key_left  = (bus.Keycode == 8'(KEY_LEFT));
    assign key_right = (bus.Keycode == 8'(KEY_RIGHT));
    assign key_jump  = (bus.Keycode == 8'(KEY_JUMP));
    assign key_walk  = key_left | key_right;

    // 11-bit intermediates keep every clamp comparison free of wrap-around.
    logic [10:0] x_ext, x_right;
    logic [9:0]  x_left;
    assign x_ext   = {1'b0, x_q};
    assign x_right = x_ext + STEP_11;
    assign x_left  = x_q - STEP_10;

    logic [10:0] y_ext, y_fall_sum;
    logic [9:0]  y_rise;
    logic [6:0]  nv_sum;
    logic [5:0]  nv;
    assign y_ext      = {1'b0, y_q};
    assign y_rise     = y_q - {4'b0, v_q};
    assign nv_sum     = {1'b0, v_q} + GRAV_7;
    assign nv         = (nv_sum > MAX_FALL_7) ? MAX_FALL_7[5:0] : nv_sum[5:0];
    assign y_fall_sum = y_ext + {5'b0, nv};

    always_comb begin
        // NOTE: every _d gets its hold value first, so no path can leave one unassigned and infer a latch.
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        v_d      = v_q;
        facing_d = facing_q;
        anim_d   = anim_q;
        div_d    = div_q;

        // Air control: horizontal motion applies in every vertical state.
        if (key_right) begin
            x_d      = (x_right > X_LIM_11) ? X_LIM_11[9:0] : x_right[9:0];
            facing_d = 1'b0;
        end else if (key_left) begin
            x_d      = (x_ext < X_MIN_11 + STEP_11) ? X_MIN_11[9:0] : x_left;
            facing_d = 1'b1;
        end

        case (state_q)
            ST_GROUND: begin
                if (key_jump) begin
                    state_d = ST_RISE;
                    v_d     = JUMP_V_6;
                end else begin
                    y_d = Y_START_11[9:0];
                end
                if (key_walk) begin
                    if (div_q == DIV_LAST) begin
                        div_d  = '0;
                        anim_d = anim_q + 1'b1;
                    end else begin
                        div_d = div_q + 1'b1;
                    end
                end else begin
                    div_d  = '0;
                    anim_d = '0;
                end
            end
            ST_RISE: begin
                y_d = (y_ext < Y_MIN_11 + {5'b0, v_q}) ? Y_MIN_11[9:0] : y_rise;
                if (v_q > GRAV_6) begin
                    v_d = v_q - GRAV_6;
                end else begin
                    v_d     = '0;
                    state_d = ST_FALL;
                end
            end
            ST_FALL: begin
                if (y_fall_sum >= Y_START_11) begin
                    y_d     = Y_START_11[9:0];
                    v_d     = '0;
                    state_d = ST_GROUND;
                end else begin
                    y_d = y_fall_sum[9:0];
                    v_d = nv;
                end
            end
            default: begin
                state_d = ST_GROUND;
                v_d     = '0;
                y_d     = Y_START_11[9:0];
            end
        endcase

        airborne_d = (state_d != ST_GROUND);
    end

    // NOTE: state registers use non-blocking assignments so all of them sample the same pre-edge values.
    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= ST_GROUND;
            x_q        <= 10'(X_START);
            y_q        <= 10'(Y_START);
            v_q        <= '0;
            facing_q   <= 1'b0;
            anim_q     <= '0;
            div_q      <= '0;
            airborne_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            v_q        <= v_d;
            facing_q   <= facing_d;
            anim_q     <= anim_d;
            div_q      <= div_d;
            airborne_q <= airborne_d;
        end
    end

    assign bus.spritex     = x_q;
    assign bus.spritey     = y_q;
    assign bus.facing_left = facing_q;
    assign bus.anim_sel    = anim_q;
    assign bus.airborne    = airborne_q;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Scoreboard bench for sprite_motion_ctrl: stimulus queues hand-derived per-frame
// expectations, a negedge monitor pops and compares them against the sprite outputs.
module tb_sprite_motion_ctrl;

    logic frame_clk = 1'b0;
    logic Reset_n   = 1'b0;

    sprite_motion_if #(.ANIM_FRAMES(4)) sif ();

    sprite_motion_ctrl dut (
        .frame_clk (frame_clk),
        .Reset_n   (Reset_n),
        .bus       (sif.slave)
    );

    always #5 frame_clk = ~frame_clk;

    typedef struct {
        int x;
        int y;
        int face;
        int anim;
        int air;
        int tag;
    } exp_t;

    exp_t exp_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   frame_tag    = 0;

    // Spritey after each edge of a jump started from the ground (edge 1 .. edge 17).
    int jump_y[17] = '{350, 342, 335, 329, 324, 320, 317, 315, 314,
                       315, 317, 320, 324, 329, 335, 342, 350};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One frame: drive the key for the coming edge and queue the outputs expected after it.
    task automatic frame(input logic [7:0] key, input int ex, input int ey,
                         input int ef, input int ea, input int eair);
        exp_t e;
        @(negedge frame_clk);
        #1;
        sif.Keycode = key;
        frame_tag++;
        e = '{x: ex, y: ey, face: ef, anim: ea, air: eair, tag: frame_tag};
        exp_q.push_back(e);
    endtask

    // Asynchronous reset mid-frame; outputs must be at reset values before any clock edge.
    task automatic do_reset();
        exp_t e;
        @(negedge frame_clk);
        #1;
        sif.Keycode = 8'd0;
        Reset_n     = 1'b0;
        #2;
        check("rst_x",     32'(sif.spritex),     32'd290);
        check("rst_y",     32'(sif.spritey),     32'd350);
        check("rst_face",  32'(sif.facing_left), 32'd0);
        check("rst_anim",  32'(sif.anim_sel),    32'd0);
        check("rst_air",   32'(sif.airborne),    32'd0);
        e = '{x: 290, y: 350, face: 0, anim: 0, air: 0, tag: -1};
        exp_q.push_back(e);
        @(negedge frame_clk);
        #1;
        Reset_n = 1'b1;
    endtask

    always @(negedge frame_clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check($sformatf("x@%0d",    e.tag), 32'(sif.spritex),     32'(e.x));
            check($sformatf("y@%0d",    e.tag), 32'(sif.spritey),     32'(e.y));
            check($sformatf("face@%0d", e.tag), 32'(sif.facing_left), 32'(e.face));
            check($sformatf("anim@%0d", e.tag), 32'(sif.anim_sel),    32'(e.anim));
            check($sformatf("air@%0d",  e.tag), 32'(sif.airborne),    32'(e.air));
        end
    end

    initial begin
        #60000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int xv;
        sif.Keycode = 8'd0;
        do_reset();

        // Walk right six frames: one full divider period advances the walk image once.
        for (int k = 1; k <= 6; k++) frame(8'd79, 290 + 2 * k, 350, 0, (k / 6) % 4, 0);
        frame(8'h41, 302, 350, 0, 0, 0);
        frame(8'd0,  302, 350, 0, 0, 0);

        // Build up some state, then reset mid-frame.
        for (int k = 1; k <= 8; k++) frame(8'd79, 302 + 2 * k, 350, 0, (k / 6) % 4, 0);
        do_reset();

        // Walk left into the X_MIN wall; animation keeps cycling while clamped.
        for (int k = 1; k <= 146; k++) begin
            xv = 290 - 2 * k;
            if (xv < 0) xv = 0;
            frame(8'd80, xv, 350, 1, (k / 6) % 4, 0);
        end
        frame(8'd0, 0, 350, 1, 0, 0);

        // Single-frame jump press, full arc, landing on edge 17.
        for (int i = 0; i < 17; i++)
            frame((i == 0) ? 8'd82 : 8'd0, 0, jump_y[i], 1, 0, (i != 16) ? 1 : 0);

        // Jump with air control, then walk into the X_LIM wall.
        do_reset();
        for (int k = 1; k <= 8; k++) frame(8'd79, 290 + 2 * k, 350, 0, (k / 6) % 4, 0);
        for (int i = 0; i < 17; i++)
            frame((i == 0) ? 8'd82 : 8'd79, 306 + ((i == 0) ? 0 : 2 * i), jump_y[i], 0, 0,
                  (i != 16) ? 1 : 0);
        for (int k = 1; k <= 140; k++) begin
            xv = 338 + 2 * k;
            if (xv > 608) xv = 608;
            frame(8'd79, xv, 350, 0, (k / 6) % 4, 0);
        end

        // Jump held: lands on edge 17, re-launches on edge 18, reset at the second apex.
        for (int i = 0; i < 26; i++)
            frame(8'd82, 608, jump_y[i % 17], 0, 0, ((i % 17) != 16) ? 1 : 0);
        do_reset();
        frame(8'd0,  290, 350, 0, 0, 0);
        frame(8'd79, 292, 350, 0, 0, 0);

        @(negedge frame_clk);
        @(negedge frame_clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/sprite_motion_ctrl.md
Name: sprite_motion_ctrl

Overview:
Per-frame player sprite motion and animation controller; successor to the single-step left/right mover. Adds the following, all parametrised:
- Horizontal motion clamped to the screen.
- Jump/gravity state machine.
- Facing flag.
- Walk-cycle animation frame selector.
Clocked by the vertical-sync frame clock. Drives the sprite position and frame select into the sprite ROM/draw logic.

Parameters:
X_START, 290, reset X position (left edge of sprite)
Y_START, 350, reset Y position; also the ground line
X_MIN, 0, leftmost legal X
X_MAX, 639, rightmost visible pixel
SPRITE_W, 32, sprite width; rightmost legal X = X_MAX-SPRITE_W+1 (X_LIM)
Y_MIN, 0, topmost legal Y
X_STEP, 2, horizontal pixels per frame
JUMP_V, 8, initial upward velocity (px/frame)
GRAVITY, 1, velocity change per frame
MAX_FALL, 8, terminal fall velocity
ANIM_FRAMES, 4, walk-cycle length (power of 2)
ANIM_DIV, 6, frames held per walk image
KEY_LEFT/KEY_RIGHT/KEY_JUMP, 80/79/82, keycodes

Ports:
frame_clk  in  1  frame clock, one rising edge per vertical sync
Reset_n  in  1  asynchronous, active-low reset
Keycode  in  8  current keyboard keycode, 0 = none
spritex  out  10  sprite X position
spritey  out  10  sprite Y position
facing_left  out  1  1 = sprite faces left
anim_sel  out  $clog2(ANIM_FRAMES)  walk image index
airborne  out  1  1 while in RISE or FALL

Behaviour:
- Reset: async on Reset_n=0, released synchronously to frame_clk.
  - spritex=X_START, spritey=Y_START, facing_left=0, anim_sel=0, airborne=0.
  - State GROUND, velocity v=0, divider count=0.
  - Reset mid-jump aborts the jump immediately.
- All registers update once per frame_clk edge. Outputs are registered; a key seen at edge N is reflected in the outputs after edge N.
- Horizontal motion is applied in every state (air control allowed):
  - KEY_RIGHT: x <= min(x+X_STEP, X_LIM); facing_left <= 0.
  - KEY_LEFT: x <= (x < X_MIN+X_STEP) ? X_MIN : x-X_STEP; facing_left <= 1.
  - Any other code: x holds; facing_left holds.
  - All comparisons are unsigned with 11-bit intermediates, so no wrap-around is possible.
- Vertical state machine, v is unsigned 6-bit:
  - GROUND, Keycode==KEY_JUMP: to RISE, v <= JUMP_V, y holds.
  - GROUND, otherwise: y = Y_START.
  - RISE: y <= max(y-v, Y_MIN), saturating at Y_MIN.
    - If v > GRAVITY: v <= v-GRAVITY.
    - Else: v <= 0, to FALL.
  - FALL: nv = min(v+GRAVITY, MAX_FALL).
    - If y+nv >= Y_START: y <= Y_START, v <= 0, to GROUND (landing).
    - Else: y <= y+nv, v <= nv.
  - A single keycode register means jump and horizontal are mutually exclusive in any frame.
  - Jump key in RISE/FALL is ignored. Jump key held through landing re-triggers RISE on the next frame.
- airborne = (state != GROUND), registered together with state.
- Animation:
  - GROUND with left/right key held: divider increments. At ANIM_DIV-1 it wraps to 0 and anim_sel <= anim_sel+1 (mod ANIM_FRAMES wrap).
  - GROUND with no horizontal key: divider=0, anim_sel=0.
  - RISE/FALL: divider and anim_sel frozen.
  - On landing, the walk cycle resumes from the frozen value.
  - The animation advances even when x is clamped at a boundary (walking into the wall).
- Unknown keycodes are treated as no key.

Test Plan:
1. Reset_n=0 mid-frame with arbitrary state, then release -> spritex=290, spritey=350, anim_sel=0, facing_left=0, airborne=0 with no clock edge needed.
2. Keycode=79 for 6 frames -> spritex 292,294,…,302; facing_left=0; anim_sel steps 0→1 after the 6th frame. Keycode=0 -> anim_sel=0, x holds.
3. Keycode=80 from x=290 for 146 frames -> x decreases by 2/frame to 0, then holds at 0; facing_left=1; anim_sel keeps cycling 0..3 with wrap.
4. Keycode=82 for one frame, then 0, defaults -> airborne=1.
   - spritey: 350, 342, 335, 329, 324, 320, 317, 315, 314 (apex, enter FALL).
   - Then 315, 317, 320, 324, 329, 335, 342, 350 (landing, airborne=0).
   - 17 edges in total.
5. Jump, then Keycode=79 during flight -> x advances 2/frame while y follows scenario 4; anim_sel frozen in air. Hold 79 at X_LIM=608 -> x stays 608.
6. Hold Keycode=82 continuously -> lands at 350 and re-enters RISE on the very next edge (v=8). Assert Reset_n=0 at the apex -> immediate return to y=350, GROUND.
